escalonador_elevador: RTL and testbench

- Call scheduler and motion sequencer for a 4-floor elevator car.
- Latches floor calls, picks the next target floor with a SCAN policy, and steps the car one floor per tick.
- Drives current-floor (andar) and target-floor (prioridade) buses into the door FSM, and interlocks motion with the door-state feedback.
- Sits between the button debouncers and the door controller; clocked by the 1 Hz tick from the clock divider.

---
 rtl/elevador_pkg.sv | 28 ++
 rtl/escalonador_elevador_seletor_alvo.sv | 58 +++++
 rtl/escalonador_elevador.sv | 157 +++++++++++++++
 tb/tb_escalonador_elevador.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// Shared types and constants for the elevator call scheduler.
// Floor, state and door-state encodings used by the scheduler and its target chooser.
package elevador_pkg;

    localparam int FLOOR_W = 2;
    localparam int NFLOORS = 4;

    localparam logic [1:0] PORTA_FECHADA = 2'b00;
    localparam logic [1:0] PORTA_ABERTA  = 2'b11;

    typedef logic [FLOOR_W-1:0] andar_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLOSE_WAIT = 3'd1,
        ST_MOVE       = 3'd2,
        ST_OPEN_WAIT  = 3'd3,
        ST_DWELL      = 3'd4
    } estado_t;

    function automatic logic [NFLOORS-1:0] um_quente(input andar_t a);
        logic [NFLOORS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/escalonador_elevador_seletor_alvo.sv
// SCAN target chooser: a call at the current floor first, then the nearest
// call in the travel direction, otherwise the nearest call behind (direction flips).
module seletor_alvo
    import elevador_pkg::*;
(
    input  logic [NFLOORS-1:0] pedidos,
    input  andar_t             andar,
    input  logic               subindo,
    output andar_t             alvo,
    output logic               novo_subindo,
    output logic               aqui
);

    logic   acima_ok;
    logic   abaixo_ok;
    andar_t acima;
    andar_t abaixo;

    // Scanning top-down for "above" and bottom-up for "below" leaves the nearest hit.
    always_comb begin
        acima_ok  = 1'b0;
        acima     = andar;
        abaixo_ok = 1'b0;
        abaixo    = andar;
        for (int i = NFLOORS - 1; i >= 0; i--) begin
            if (pedidos[i] && (andar_t'(i) > andar)) begin
                acima_ok = 1'b1;
                acima    = andar_t'(i);
            end
        end
        for (int i = 0; i < NFLOORS; i++) begin
            if (pedidos[i] && (andar_t'(i) < andar)) begin
                abaixo_ok = 1'b1;
                abaixo    = andar_t'(i);
            end
        end
    end

    always_comb begin
        aqui         = pedidos[andar];
        alvo         = andar;
        novo_subindo = subindo;
        if (!aqui) begin
            if (subindo && acima_ok) begin
                alvo = acima;
            end else if (subindo && abaixo_ok) begin
                alvo         = abaixo;
                novo_subindo = 1'b0;
            end else if (!subindo && abaixo_ok) begin
                alvo = abaixo;
            end else if (!subindo && acima_ok) begin
                alvo         = acima;
                novo_subindo = 1'b1;
            end
        end
    end

endmodule

// File: rtl/escalonador_elevador.sv
// Call latch, SCAN scheduling and one-floor-per-tick motion sequencing for a
// 4-floor car, interlocked with the door controller's state feedback.
module escalonador_elevador
    import elevador_pkg::*;
#(
    parameter int unsigned DWELL        = 3,
    parameter logic [1:0]  HOME         = 2'd0,
    parameter int unsigned IDLE_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] chamada,
    input  logic [1:0] porta_estado,
    input  logic       porta_aberta,
    input  logic       cheio,
    output logic [1:0] andar,
    output logic [1:0] prioridade,
    output logic [3:0] pendentes,
    output logic       subindo,
    output logic       movendo,
    output logic [2:0] estado
);

    localparam logic [3:0] DWELL_FIM = 4'(DWELL - 1);

    estado_t            st;
    logic [3:0]         dwell_cnt;
    logic [7:0]         idle_cnt;
    logic               home_req;
    logic [NFLOORS-1:0] sel_pedidos;
    logic [NFLOORS-1:0] limpa;
    andar_t             alvo;
    logic               novo_subindo;
    logic               aqui;
    andar_t             mv_alvo;
    andar_t             passo;
    logic               ocioso_esgotado;
    logic               dwell_fim;

    assign estado          = st;
    assign dwell_fim       = (dwell_cnt == DWELL_FIM);
    assign ocioso_esgotado = (IDLE_TIMEOUT != 0) &&
                             (({1'b0, idle_cnt} + 9'd1) >= 9'(IDLE_TIMEOUT));

    // While dwelling, the chooser must see only the calls left after serving this floor.
    always_comb begin
        if (st == ST_DWELL) begin
            sel_pedidos = pendentes & ~um_quente(andar);
        end else begin
            sel_pedidos = pendentes | (home_req ? um_quente(HOME) : '0);
        end
        limpa = (st == ST_DWELL && dwell_fim && !cheio) ? um_quente(andar) : '0;
    end

    seletor_alvo u_seletor (
        .pedidos      (sel_pedidos),
        .andar        (andar),
        .subindo      (subindo),
        .alvo         (alvo),
        .novo_subindo (novo_subindo),
        .aqui         (aqui)
    );

    // Retarget only to a call at the car or strictly between it and the current target.
    always_comb begin
        mv_alvo = prioridade;
        if (aqui) begin
            mv_alvo = andar;
        end else if (prioridade > andar) begin
            if (alvo > andar && alvo < prioridade) mv_alvo = alvo;
        end else begin
            if (alvo < andar && alvo > prioridade) mv_alvo = alvo;
        end
        passo = andar;
        if (mv_alvo > andar) begin
            passo = andar + 2'd1;
        end else if (mv_alvo < andar) begin
            passo = andar - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= ST_IDLE;
            andar      <= '0;
            prioridade <= '0;
            pendentes  <= '0;
            subindo    <= 1'b1;
            movendo    <= 1'b0;
            dwell_cnt  <= '0;
            idle_cnt   <= '0;
            home_req   <= 1'b0;
        end else begin
            pendentes <= (pendentes | chamada) & ~limpa;
            movendo   <= 1'b0;
            if (st != ST_IDLE) idle_cnt <= '0;
            case (st)
                ST_IDLE: begin
                    prioridade <= andar;
                    if (idle_cnt != 8'hFF) idle_cnt <= idle_cnt + 8'd1;
                    if (aqui) begin
                        st <= ST_OPEN_WAIT;
                    end else if (alvo != andar) begin
                        prioridade <= alvo;
                        subindo    <= novo_subindo;
                        idle_cnt   <= '0;
                        st         <= ST_CLOSE_WAIT;
                    end else if (ocioso_esgotado && andar != HOME) begin
                        home_req <= 1'b1;
                    end
                end
                ST_CLOSE_WAIT: begin
                    if (porta_estado == PORTA_FECHADA) begin
                        st      <= ST_MOVE;
                        movendo <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (mv_alvo == andar) begin
                        prioridade <= andar;
                        st         <= ST_OPEN_WAIT;
                    end else begin
                        andar      <= passo;
                        prioridade <= mv_alvo;
                        if (passo == mv_alvo) begin
                            st <= ST_OPEN_WAIT;
                        end else begin
                            movendo <= 1'b1;
                        end
                    end
                end
                ST_OPEN_WAIT: begin
                    if (porta_aberta && porta_estado == PORTA_ABERTA) begin
                        st        <= ST_DWELL;
                        dwell_cnt <= '0;
                    end
                end
                ST_DWELL: begin
                    if (!dwell_fim) begin
                        dwell_cnt <= dwell_cnt + 4'd1;
                    end else if (!cheio) begin
                        home_req <= 1'b0;
                        if (alvo != andar) begin
                            prioridade <= alvo;
                            subindo    <= novo_subindo;
                            st         <= ST_CLOSE_WAIT;
                        end else begin
                            st <= ST_IDLE;
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_elevador.sv
// Bench for escalonador_elevador: directed scenarios plus random calls and car-full
// events, every tick compared against a floor-array reference model.
module tb_escalonador_elevador;

    localparam int W       = 13;
    localparam int DWELL_T = 3;
    localparam int HOME_F  = 0;
    localparam int TIMEOUT = 8;
    localparam int S_IDLE  = 0;
    localparam int S_CW    = 1;
    localparam int S_MOVE  = 2;
    localparam int S_OW    = 3;
    localparam int S_DW    = 4;
    localparam logic [W-1:0] RESET_VEC = {2'd0, 2'd0, 4'd0, 1'b1, 1'b0, 3'd0};

    logic       clk;
    logic       reset;
    logic [3:0] chamada;
    logic [1:0] porta_estado;
    logic       porta_aberta;
    logic       cheio;
    logic [1:0] andar;
    logic [1:0] prioridade;
    logic [3:0] pendentes;
    logic       subindo;
    logic       movendo;
    logic [2:0] estado;

    escalonador_elevador #(
        .DWELL        (DWELL_T),
        .HOME         (2'(HOME_F)),
        .IDLE_TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .chamada      (chamada),
        .porta_estado (porta_estado),
        .porta_aberta (porta_aberta),
        .cheio        (cheio),
        .andar        (andar),
        .prioridade   (prioridade),
        .pendentes    (pendentes),
        .subindo      (subindo),
        .movendo      (movendo),
        .estado       (estado)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_vec;
    int n_err;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] dut_vec();
        return {andar, prioridade, pendentes, subindo, movendo, estado};
    endfunction

    // ---------------- reference model (floor arrays, integer state) ----------------
    int m_andar, m_prio, m_state, m_dwell, m_idle;
    bit m_up, m_mov, m_home;
    bit m_pend[4];

    task automatic model_reset();
        m_andar = 0; m_prio = 0; m_state = S_IDLE; m_dwell = 0; m_idle = 0;
        m_up = 1'b1; m_mov = 1'b0; m_home = 1'b0;
        for (int f = 0; f < 4; f++) m_pend[f] = 1'b0;
        exp_q.delete();
    endtask

    // SCAN choice: call here, else nearest ahead, else nearest behind (turn around).
    function automatic void escolhe(input bit req[4], input int cur, input bit up,
                                    output int tgt, output bit dir);
        int above;
        int below;
        above = -1;
        below = -1;
        tgt   = cur;
        dir   = up;
        if (!req[cur]) begin
            for (int f = 3; f > cur; f--) if (req[f]) above = f;
            for (int f = 0; f < cur; f++) if (req[f]) below = f;
            if (up) begin
                if (above >= 0) tgt = above;
                else if (below >= 0) begin tgt = below; dir = 1'b0; end
            end else begin
                if (below >= 0) tgt = below;
                else if (above >= 0) begin tgt = above; dir = 1'b1; end
            end
        end
    endfunction

    task automatic model_step();
        bit req[4];
        bit limpa[4];
        int t, dest, ns, n_andar, n_prio, n_dwell, n_idle;
        bit d, n_up, n_home;
        for (int f = 0; f < 4; f++) begin
            req[f]   = m_pend[f];
            limpa[f] = 1'b0;
        end
        if (m_home) req[HOME_F] = 1'b1;
        ns = m_state; n_andar = m_andar; n_prio = m_prio; n_dwell = m_dwell;
        n_idle = m_idle; n_up = m_up; n_home = m_home;
        case (m_state)
            S_IDLE: begin
                n_prio = m_andar;
                n_idle = (m_idle < 255) ? m_idle + 1 : 255;
                escolhe(req, m_andar, m_up, t, d);
                if (req[m_andar]) ns = S_OW;
                else if (t != m_andar) begin
                    n_prio = t; n_up = d; n_idle = 0; ns = S_CW;
                end else if (TIMEOUT != 0 && m_idle + 1 >= TIMEOUT && m_andar != HOME_F)
                    n_home = 1'b1;
            end
            S_CW: if (porta_estado == 2'b00) ns = S_MOVE;
            S_MOVE: begin
                escolhe(req, m_andar, m_up, t, d);
                dest = m_prio;
                if (req[m_andar]) dest = m_andar;
                else if (m_prio > m_andar && t > m_andar && t < m_prio) dest = t;
                else if (m_prio < m_andar && t < m_andar && t > m_prio) dest = t;
                if (dest == m_andar) begin
                    n_prio = m_andar; ns = S_OW;
                end else begin
                    n_andar = (dest > m_andar) ? m_andar + 1 : m_andar - 1;
                    n_prio  = dest;
                    if (n_andar == dest) ns = S_OW;
                end
            end
            S_OW: if (porta_aberta) begin ns = S_DW; n_dwell = 0; end
            S_DW: begin
                if (m_dwell < DWELL_T - 1) n_dwell = m_dwell + 1;
                else if (!cheio) begin
                    limpa[m_andar] = 1'b1;
                    n_home = 1'b0;
                    for (int f = 0; f < 4; f++) req[f] = m_pend[f] && (f != m_andar);
                    escolhe(req, m_andar, m_up, t, d);
                    if (t != m_andar) begin n_prio = t; n_up = d; ns = S_CW; end
                    else ns = S_IDLE;
                end
            end
            default: ns = S_IDLE;
        endcase
        if (m_state != S_IDLE) n_idle = 0;
        for (int f = 0; f < 4; f++) m_pend[f] = (m_pend[f] || chamada[f]) && !limpa[f];
        m_state = ns; m_andar = n_andar; m_prio = n_prio; m_dwell = n_dwell;
        m_idle = n_idle; m_up = n_up; m_home = n_home;
        m_mov = (ns == S_MOVE);
    endtask

    function automatic logic [W-1:0] model_vec();
        logic [3:0] p;
        for (int f = 0; f < 4; f++) p[f] = m_pend[f];
        return {2'(m_andar), 2'(m_prio), p, m_up, m_mov, 3'(m_state)};
    endfunction

    // ---------------- door environment and driver tasks ----------------
    int porta_pos;

    task automatic door_step();
        bit want;
        want = !movendo && ((andar == prioridade) || (cheio && porta_pos != 0));
        if (want && porta_pos < 3) porta_pos++;
        else if (!want && porta_pos > 0) porta_pos--;
        porta_estado = 2'(porta_pos);
        porta_aberta = (porta_pos == 3);
    endtask

    task automatic tick();
        model_step();
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        check_val("ciclo", 16'(dut_vec()), 16'(exp_q.pop_front()));
        door_step();
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        int n;
        n = 0;
        while (estado != 3'(st) && n < budget) begin tick(); n++; end
        check_val(tag, 16'(estado == 3'(st)), 16'd1);
    endtask

    task automatic count_state(input int st, input int budget, output int n);
        n = 0;
        while (estado == 3'(st) && n < budget) begin n++; tick(); end
    endtask

    task automatic pulse_call(input logic [3:0] c);
        chamada = c;
        tick();
        chamada = 4'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        n_vec = 0; n_err = 0;
        reset = 1'b0; chamada = 4'd0; cheio = 1'b0;
        porta_pos = 3; porta_estado = 2'b11; porta_aberta = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_val", 16'(dut_vec()), 16'(RESET_VEC));
        @(negedge clk);
        reset = 1'b1;

        // Call to floor 3 from 0: three closing ticks, three floors, three dwell ticks
        pulse_call(4'b1000);
        wait_state(S_CW, 5, "s1_cw");
        check_val("s1_prio", 16'(prioridade), 16'd3);
        count_state(S_CW, 20, n);
        check_val("s1_cw_ticks", 16'(n), 16'd3);
        for (int f = 1; f <= 3; f++) begin
            tick();
            check_val("s1_andar", 16'(andar), 16'(f));
        end
        check_val("s1_ow", 16'(estado), 16'(S_OW));
        wait_state(S_DW, 10, "s1_dw");
        count_state(S_DW, 20, n);
        check_val("s1_dw_ticks", 16'(n), 16'(DWELL_T));
        check_val("s1_fim", 16'({estado, pendentes, prioridade}), 16'({3'd0, 4'd0, 2'd3}));

        // Idle at 3 without calls: parks at HOME after the timeout
        count_state(S_IDLE, 30, n);
        check_val("s5_idle_ticks", 16'(n), 16'(TIMEOUT + 1));
        check_val("s5_home", 16'({estado, prioridade, pendentes}), 16'({3'd1, 2'd0, 4'd0}));
        wait_state(S_OW, 20, "s5_ow");
        check_val("s5_andar", 16'({andar, pendentes}), 16'({2'd0, 4'd0}));
        wait_state(S_IDLE, 20, "s5_idle");

        // At 2 going up with only 0 and 1 pending: turn around, serve 1 then 0
        pulse_call(4'b0100);
        wait_state(S_DW, 30, "s3_dw");
        check_val("s3_andar2", 16'({andar, subindo}), 16'({2'd2, 1'b1}));
        pulse_call(4'b0011);
        wait_state(S_CW, 10, "s3_cw");
        check_val("s3_vira", 16'({subindo, prioridade}), 16'({1'b0, 2'd1}));
        wait_state(S_OW, 20, "s3_ow1");
        check_val("s3_andar1", 16'(andar), 16'd1);
        wait_state(S_CW, 20, "s3_cw0");
        check_val("s3_prio0", 16'(prioridade), 16'd0);
        wait_state(S_OW, 20, "s3_ow0");
        check_val("s3_andar0", 16'(andar), 16'd0);
        wait_state(S_IDLE, 20, "s3_idle");

        // Intermediate stop: call at 2 while travelling 0 -> 3
        pulse_call(4'b1000);
        n = 0;
        while (andar != 2'd1 && n < 20) begin tick(); n++; end
        check_val("s2_andar1", 16'(andar), 16'd1);
        pulse_call(4'b0100);
        wait_state(S_OW, 5, "s2_ow");
        check_val("s2_parada", 16'({andar, prioridade}), 16'({2'd2, 2'd2}));
        wait_state(S_CW, 20, "s2_cw");
        check_val("s2_retoma", 16'(prioridade), 16'd3);
        wait_state(S_OW, 20, "s2_ow3");
        check_val("s2_andar3", 16'(andar), 16'd3);
        wait_state(S_IDLE, 20, "s2_idle");

        // Car full during dwell at 1 with a call to 3 pending
        pulse_call(4'b0010);
        wait_state(S_DW, 30, "s4_dw");
        check_val("s4_andar1", 16'(andar), 16'd1);
        cheio = 1'b1;
        pulse_call(4'b1000);
        repeat (6) tick();
        check_val("s4_hold", 16'({estado, pendentes}), 16'({3'd4, 4'b1010}));
        cheio = 1'b0;
        wait_state(S_CW, 10, "s4_cw");
        check_val("s4_sai", 16'({pendentes, prioridade}), 16'({4'b1000, 2'd3}));

        // Asynchronous reset while moving past floor 2
        n = 0;
        while (!(estado == 3'd2 && andar == 2'd2) && n < 30) begin tick(); n++; end
        check_val("s6_move2", 16'(estado == 3'd2 && andar == 2'd2), 16'd1);
        reset = 1'b0;
        #1;
        check_val("s6_reset", 16'(dut_vec()), 16'(RESET_VEC));
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Random calls and car-full episodes
        for (int i = 0; i < 800; i++) begin
            chamada = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            if (cheio) cheio = ($urandom_range(0, 3) != 0);
            else       cheio = ($urandom_range(0, 24) == 0);
            tick();
        end

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
